// File: rtl/td4_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : td4_prog_loader
//  Description : Program-memory loader for the 4-bit TD4 CPU. Takes a byte
//                stream over valid/ready, writes it into a 16x8 instruction
//                memory, holds the CPU in reset while loading and releases
//                it once the image is complete. It also serves the CPU's
//                combinational instruction-fetch port.
//  Options     : TD4_PROG_LOADER_CHECKSUM_EN - when defined, one checksum
//                byte follows the image; the CPU is only released if the
//                image bytes plus the checksum sum to zero (mod 2**DATA_W).
//  Revision    : 1.0 - initial release
// ============================================================================
module td4_prog_loader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_req,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              cpu_reset_n,
    output logic              busy,
    output logic              err,
    output logic [ADDR_W-1:0] load_addr
);

    localparam int                c_DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = {ADDR_W{1'b1}};

`ifdef TD4_PROG_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CHECK = 3'd2,
        S_RUN   = 3'd3,
        S_ERROR = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd3,
        S_ERROR = 3'd4
    } state_t;
`endif

    state_t              r_state;
    state_t              w_next_state;
    logic                r_load_req_q;
    logic [ADDR_W-1:0]   r_load_addr;
    logic                r_cpu_reset_n;
    logic [DATA_W-1:0]   r_mem [c_DEPTH];
    logic                w_ld_ready;
    logic                w_start;
    logic                w_accept;
    logic                w_enter_load;
    logic                w_last;

    assign w_start      = load_req & ~r_load_req_q;
    assign w_accept     = ld_valid & w_ld_ready;
    assign w_last       = (r_load_addr == c_LAST_ADDR);
    // Only IDLE/RUN/ERROR can move into LOAD, so this marks a fresh load.
    assign w_enter_load = (w_next_state == S_LOAD) && (r_state != S_LOAD);

`ifdef TD4_PROG_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] r_sum;
    logic              r_err;
    logic [DATA_W-1:0] w_sum_final;

    assign w_sum_final = r_sum + ld_data;

    // Running sum of accepted image bytes; cleared at the start of a load.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sum <= '0;
        end else if (w_enter_load) begin
            r_sum <= '0;
        end else if (r_state == S_LOAD && w_accept) begin
            r_sum <= w_sum_final;
        end
    end

    // ERROR is left only through a new load, so err simply tracks it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else begin
            r_err <= (w_next_state == S_ERROR);
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    // State register with load_req edge-detect sample.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_load_req_q <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_load_req_q <= load_req;
        end
    end

    // Next-state decode; ld_ready is high exactly in the byte-taking states.
    always_comb begin
        w_next_state = r_state;
        w_ld_ready   = 1'b0;
        case (r_state)
            S_IDLE, S_RUN, S_ERROR: begin
                if (w_start) begin
                    w_next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                w_ld_ready = 1'b1;
                if (ld_valid && w_last) begin
`ifdef TD4_PROG_LOADER_CHECKSUM_EN
                    w_next_state = S_CHECK;
`else
                    w_next_state = S_RUN;
`endif
                end
            end
`ifdef TD4_PROG_LOADER_CHECKSUM_EN
            S_CHECK: begin
                w_ld_ready = 1'b1;
                if (ld_valid) begin
                    w_next_state = (w_sum_final == '0) ? S_RUN : S_ERROR;
                end
            end
`endif
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Write pointer: restarts at 0 for each load, advances only on image accepts.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_load_addr <= '0;
        end else if (w_enter_load) begin
            r_load_addr <= '0;
        end else if (r_state == S_LOAD && w_accept) begin
            r_load_addr <= r_load_addr + ADDR_W'(1);
        end
    end

    // CPU runs only while RUN; set on the edge that enters RUN.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cpu_reset_n <= 1'b0;
        end else begin
            r_cpu_reset_n <= (w_next_state == S_RUN);
        end
    end

    // Instruction memory: not reset so a partial load keeps older contents.
    always_ff @(posedge clock) begin
        if (r_state == S_LOAD && w_accept) begin
            r_mem[r_load_addr] <= ld_data;
        end
    end

    assign rd_data     = r_mem[rd_addr];
    assign ld_ready    = w_ld_ready;
    assign busy        = w_ld_ready;
    assign cpu_reset_n = r_cpu_reset_n;
    assign load_addr   = r_load_addr;

endmodule
`default_nettype wire

// File: doc/td4_prog_loader.md
Name: td4_prog_loader

Overview:
- Program-memory writer for the 4-bit TD4 CPU. It accepts a byte stream over a valid/ready interface and writes it into the 16x8 instruction memory.
- Holds the CPU in reset while loading and releases it when the image is complete.
- Also serves the CPU's combinational instruction-fetch read port: CPU pc in, opcode out.

Parameters:
- ADDR_W, 4, instruction address width; memory depth is 2**ADDR_W.
- DATA_W, 8, instruction width.

Ports:
- clock, input, 1, single clock; all state updates on posedge.
- reset, input, 1, asynchronous, active-high reset.
- load_req, input, 1, load request; rising edge (registered edge detect) starts a load.
- ld_valid, input, 1, ld_data holds a valid byte.
- ld_data, input, DATA_W, program byte.
- ld_ready, output, 1, loader accepts a byte this cycle.
- rd_addr, input, ADDR_W, CPU fetch address (CPU pc).
- rd_data, output, DATA_W, instruction at rd_addr, combinational.
- cpu_reset_n, output, 1, active-low CPU reset, registered.
- busy, output, 1, high in LOAD or CHECK.
- err, output, 1, last load failed checksum.
- load_addr, output, ADDR_W, next write address.

Behaviour:
- States: IDLE, LOAD, CHECK (only with macro), RUN, ERROR.
- Reset values:
  - state=IDLE, cpu_reset_n=0, ld_ready=0, busy=0, err=0, load_addr=0.
  - Running sum=0; load_req edge-detect register=0, so a load_req held high through reset triggers one load.
  - Memory contents are NOT reset.
- Start condition: rising edge of load_req (load_req=1 and previous sample=0).
  - In IDLE, RUN or ERROR it moves the block to LOAD next cycle.
  - On entry to LOAD: load_addr=0, sum=0, err=0, cpu_reset_n=0 (the same edge the state changes).
  - Edges seen during LOAD or CHECK are ignored.
- ld_ready = (state==LOAD or CHECK), decoded combinationally from state.
- Accept = ld_valid & ld_ready.
- LOAD:
  - Each accept writes mem[load_addr] <= ld_data, load_addr += 1 (wraps to 0 after 15), sum <= sum + ld_data (mod 2**DATA_W).
  - No accept means no write and no increment; ld_valid gaps are allowed indefinitely.
- After the accept at load_addr=2**ADDR_W-1, the next state is CHECK (macro defined) or RUN (macro undefined).
- RUN:
  - cpu_reset_n=1 from the first RUN cycle: the flop is set when next_state==RUN.
  - No writes occur; ld_ready=0.
- ERROR: cpu_reset_n=0, err=1, ld_ready=0; exit only via a load_req edge.
- Read port:
  - rd_data = mem[rd_addr] at all times, independent of state.
  - A read to the address written in the same cycle returns old data; the new data appears next cycle.
- Reset mid-load: returns to IDLE immediately.
  - Bytes already written stay in memory; unwritten addresses keep their prior contents.
  - cpu_reset_n=0.
- load_req edge in RUN: CPU goes back into reset at the next clock, which truncates the program.

Optional Feature:
- Macro TD4_PROG_LOADER_CHECKSUM_EN.
- Defined:
  - After 16 bytes, state CHECK accepts exactly one extra byte c.
  - If (sum + c) mod 256 == 0, go to RUN with err=0; otherwise go to ERROR with err=1.
  - The checksum byte is never written to memory.
- Undefined:
  - The CHECK state and sum register are absent; the 16th accept goes straight to RUN.
  - err is tied to 0.

Test Plan:
- Reset, pulse load_req, stream 0x00..0x0F back-to-back (macro off):
  - ld_ready high for 16 cycles; cpu_reset_n=1 the cycle after the 16th accept.
  - rd_addr=5 gives rd_data=0x05; rd_addr=15 gives 0x0F.
- Backpressure: same stream with ld_valid low on alternate cycles:
  - load_addr advances only on accepts.
  - Final memory matches the previous test; cpu_reset_n stays 0 until the 16th accept.
- Macro on, pass case: sixteen 0x01 bytes plus checksum 0xF0 gives RUN, err=0, cpu_reset_n=1.
- Macro on, fail case: same bytes with 0xF1 gives ERROR, err=1, cpu_reset_n=0.
  - A new load_req edge then clears err and busy=1 next cycle.
- Preload memory with 0xAA, start a load, accept 7 bytes 0x10..0x16, assert reset:
  - State IDLE, load_addr=0, cpu_reset_n=0.
  - mem[0..6]=0x10..0x16; mem[7..15]=0xAA.
- In RUN, hold load_req high for 40 cycles:
  - Exactly one reload starts: cpu_reset_n=0 next clock, busy=1.
  - After 16 accepts the block enters RUN and stays there while load_req remains high.
